// File: rtl/pc_control_fsm.sv
// Multi-cycle control FSM for the single-issue MIPS-subset core. Sequences FETCH/DECODE/EXEC/MEM/WB,
// handshakes with imem/dmem and drives the PC, regfile, ALU and dmem controls.
module pc_control_fsm #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        zero,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic        bus_err
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] PC_JR     = 2'd3;
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_XOR   = 2'd2;
  localparam logic [1:0] ALU_SLT   = 2'd3;
  localparam logic [1:0] DST_RT    = 2'd0;
  localparam logic [1:0] DST_RD    = 2'd1;
  localparam logic [1:0] DST_RA    = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_DMEM   = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 32'd1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(32'd0);
  localparam bit               WD_EN     = (WAIT_MAX != 32'd0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       ir_q, ir_d;
  logic              bus_err_q, bus_err_d;

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       exec_op_s;
  logic       alu_src_s;
  logic [1:0] alu_op_s;
  logic       wait_expired_s;
  logic       unused_ir_s;

  assign opcode_s       = ir_q[31:26];
  assign funct_s        = ir_q[5:0];
  assign unused_ir_s    = ^ir_q[25:6];
  assign wait_expired_s = WD_EN && (wait_q == WAIT_LAST);
  assign bus_err        = bus_err_q;

  // Instruction class decode from the IR: ALU controls and whether the op needs EXEC.
  always_comb begin
    exec_op_s = 1'b0;
    alu_src_s = 1'b0;
    alu_op_s  = ALU_ADD;
    case (opcode_s)
      OP_R: begin
        case (funct_s)
          FN_ADD:  begin exec_op_s = 1'b1; alu_op_s = ALU_ADD; end
          FN_SUB:  begin exec_op_s = 1'b1; alu_op_s = ALU_SUB; end
          FN_SLT:  begin exec_op_s = 1'b1; alu_op_s = ALU_SLT; end
          default: begin exec_op_s = 1'b0; end
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin exec_op_s = 1'b1; alu_src_s = 1'b1; alu_op_s = ALU_ADD; end
      OP_XORI:               begin exec_op_s = 1'b1; alu_src_s = 1'b1; alu_op_s = ALU_XOR; end
      OP_BEQ, OP_BNE:        begin exec_op_s = 1'b1; alu_op_s = ALU_SUB; end
      default:               begin exec_op_s = 1'b0; end
    endcase
  end

  // Next-state, wait counter and output decode.
  always_comb begin
    state_d   = state_q;
    wait_d    = WAIT_ZERO;
    ir_d      = ir_q;
    bus_err_d = bus_err_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_NEXT;
    reg_we    = 1'b0;
    reg_dst   = DST_RT;
    wb_sel    = WB_ALU;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = ~reset;
        if (imem_ready) begin
          ir_we   = ~reset;
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (wait_expired_s) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_DECODE: begin
        if (opcode_s == OP_J) begin
          pc_we   = 1'b1;
          pc_sel  = PC_JUMP;
          state_d = S_FETCH;
        end else if (opcode_s == OP_JAL) begin
          pc_we   = 1'b1;
          pc_sel  = PC_JUMP;
          reg_we  = 1'b1;
          reg_dst = DST_RA;
          wb_sel  = WB_PC4;
          state_d = S_FETCH;
        end else if ((opcode_s == OP_R) && (funct_s == FN_JR)) begin
          pc_we   = 1'b1;
          pc_sel  = PC_JR;
          state_d = S_FETCH;
        end else if (exec_op_s) begin
          state_d = S_EXEC;
        end else begin
          // Unsupported encodings are skipped rather than trapped.
          illegal = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = PC_NEXT;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src = alu_src_s;
        alu_op  = alu_op_s;
        if ((opcode_s == OP_BEQ) || (opcode_s == OP_BNE)) begin
          pc_we   = 1'b1;
          pc_sel  = (((opcode_s == OP_BEQ) && zero) || ((opcode_s == OP_BNE) && !zero)) ? PC_BRANCH : PC_NEXT;
          state_d = S_FETCH;
        end else if ((opcode_s == OP_LW) || (opcode_s == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_src  = alu_src_s;
        alu_op   = alu_op_s;
        dmem_req = 1'b1;
        dmem_we  = (opcode_s == OP_SW);
        if (dmem_ready) begin
          if (opcode_s == OP_SW) begin
            pc_we   = 1'b1;
            pc_sel  = PC_NEXT;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired_s) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_WB: begin
        alu_src = alu_src_s;
        alu_op  = alu_op_s;
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = PC_NEXT;
        reg_dst = (opcode_s == OP_R) ? DST_RD : DST_RT;
        wb_sel  = (opcode_s == OP_LW) ? WB_DMEM : WB_ALU;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, wait counter, IR and sticky bus error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= WAIT_ZERO;
      ir_q      <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ir_q      <= ir_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_pc_control_fsm.sv
// Directed self-checking bench for pc_control_fsm: one default instance for instruction
// sequencing and one with WAIT_MAX=4 for the watchdog.
module tb_pc_control_fsm;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8c23_0004;
  localparam logic [31:0] I_SW   = 32'hac23_0004;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_ADDI = 32'h2022_0005;

  localparam logic [31:0] ALU_INSTR [4] = '{32'h2022_0005, 32'h3822_0005, 32'h0022_1822, 32'h0022_182a};
  localparam logic [2:0]  ALU_EXP   [4] = '{3'b1_00, 3'b1_10, 3'b0_01, 3'b0_11};
  localparam logic [1:0]  ALU_DST   [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
  localparam logic [31:0] BR_INSTR  [4] = '{32'h1022_0003, 32'h1022_0003, 32'h1422_0003, 32'h1422_0003};
  localparam logic        BR_ZERO   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [1:0]  BR_SEL    [4] = '{2'd2, 2'd0, 2'd0, 2'd2};
  localparam logic [31:0] JMP_INSTR [3] = '{32'h0800_0010, 32'h0c00_0010, 32'h03e0_0008};
  localparam logic [1:0]  JMP_SEL   [3] = '{2'd1, 2'd1, 2'd3};
  localparam logic        JMP_LINK  [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic [31:0] ILL_INSTR [2] = '{32'hfc00_0000, 32'h0000_0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_ready, dmem_ready, zero;
  logic [31:0] instr;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src, illegal, bus_err;
  logic [1:0]  pc_sel, reg_dst, wb_sel, alu_op;

  logic        wd_reset, wd_imem_ready, wd_dmem_ready, wd_zero;
  logic [31:0] wd_instr;
  logic        wd_imem_req, wd_dmem_req, wd_dmem_we, wd_ir_we, wd_pc_we, wd_reg_we, wd_alu_src;
  logic        wd_illegal, wd_bus_err;
  logic [1:0]  wd_pc_sel, wd_reg_dst, wd_wb_sel, wd_alu_op;

  int checks = 0;
  int errors = 0;

  pc_control_fsm u_dut (
    .clk(clk), .reset(reset), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .zero(zero), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err)
  );

  pc_control_fsm #(.WAIT_MAX(4), .WAIT_W(8)) u_wd (
    .clk(clk), .reset(wd_reset), .instr(wd_instr), .imem_ready(wd_imem_ready),
    .dmem_ready(wd_dmem_ready), .zero(wd_zero), .imem_req(wd_imem_req), .dmem_req(wd_dmem_req),
    .dmem_we(wd_dmem_we), .ir_we(wd_ir_we), .pc_we(wd_pc_we), .pc_sel(wd_pc_sel),
    .reg_we(wd_reg_we), .reg_dst(wd_reg_dst), .wb_sel(wd_wb_sel), .alu_src(wd_alu_src),
    .alu_op(wd_alu_op), .illegal(wd_illegal), .bus_err(wd_bus_err)
  );

  task automatic tick(input logic [31:0] i_word, input logic i_rdy, input logic d_rdy, input logic z);
    @(negedge clk);
    instr      = i_word;
    imem_ready = i_rdy;
    dmem_ready = d_rdy;
    zero       = z;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr = I_ADD; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b0;
    wd_reset = 1'b1; wd_instr = 32'd0; wd_imem_ready = 1'b0; wd_dmem_ready = 1'b0; wd_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({pc_we, reg_we, dmem_req, ir_we, illegal, bus_err, pc_sel, reg_dst, wb_sel, alu_src, alu_op} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {pc_we, reg_we, dmem_req, ir_we, illegal, bus_err, pc_sel, reg_dst, wb_sel, alu_src, alu_op});
    end
    reset = 1'b0; imem_ready = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_release_imem_req: got %b required 1", imem_req); end
    checks++;
    if ({pc_we, reg_we, dmem_req} !== 3'b000) begin
      errors++; $display("FAIL reset_release_strobes: got %b required 000", {pc_we, reg_we, dmem_req});
    end
  endtask

  task automatic test_add();
    for (int c = 1; c <= 4; c++) begin
      tick((c == 1) ? I_ADD : 32'hffff_ffff, 1'b1, 1'b1, 1'b0);
      checks++;
      if (pc_we !== (c == 4)) begin errors++; $display("FAIL add_pc_we c%0d: got %b required %b", c, pc_we, c == 4); end
      checks++;
      if (reg_we !== (c == 4)) begin errors++; $display("FAIL add_reg_we c%0d: got %b required %b", c, reg_we, c == 4); end
      if (c == 1) begin
        checks++;
        if ({imem_req, ir_we} !== 2'b11) begin errors++; $display("FAIL add_fetch c1: got %b required 11", {imem_req, ir_we}); end
      end
      if (c == 4) begin
        checks++;
        if ({pc_sel, reg_dst, wb_sel} !== 6'b00_01_00) begin
          errors++; $display("FAIL add_wb_ctrl: got %b required 000100", {pc_sel, reg_dst, wb_sel});
        end
      end
    end
  endtask

  task automatic test_alu();
    for (int v = 0; v < 4; v++) begin
      for (int c = 1; c <= 4; c++) begin
        tick((c == 1) ? ALU_INSTR[v] : 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pc_we !== (c == 4)) begin errors++; $display("FAIL alu%0d_pc_we c%0d: got %b required %b", v, c, pc_we, c == 4); end
        if (c == 3) begin
          checks++;
          if ({alu_src, alu_op} !== ALU_EXP[v]) begin
            errors++; $display("FAIL alu%0d_ctrl: got %b required %b", v, {alu_src, alu_op}, ALU_EXP[v]);
          end
        end
        if (c == 4) begin
          checks++;
          if ({reg_we, reg_dst, wb_sel} !== {1'b1, ALU_DST[v], 2'd0}) begin
            errors++; $display("FAIL alu%0d_wb: got %b required %b", v, {reg_we, reg_dst, wb_sel}, {1'b1, ALU_DST[v], 2'd0});
          end
        end
      end
    end
  endtask

  task automatic test_branch();
    for (int v = 0; v < 4; v++) begin
      for (int c = 1; c <= 3; c++) begin
        tick((c == 1) ? BR_INSTR[v] : 32'h0000_0000, 1'b1, 1'b1, BR_ZERO[v]);
        checks++;
        if ({pc_we, reg_we} !== {(c == 3), 1'b0}) begin
          errors++; $display("FAIL br%0d_strobes c%0d: got %b required %b", v, c, {pc_we, reg_we}, {(c == 3), 1'b0});
        end
        if (c == 3) begin
          checks++;
          if ({pc_sel, alu_src, alu_op} !== {BR_SEL[v], 3'b0_01}) begin
            errors++; $display("FAIL br%0d_exec: got %b required %b", v, {pc_sel, alu_src, alu_op}, {BR_SEL[v], 3'b0_01});
          end
        end
      end
    end
  endtask

  task automatic test_lw_wait();
    int req_cycles = 0;
    for (int c = 1; c <= 10; c++) begin
      tick((c == 1) ? I_LW : 32'h0000_0000, 1'b1, !((c >= 4) && (c <= 8)), 1'b0);
      if (dmem_req === 1'b1) req_cycles++;
      checks++;
      if ({pc_we, reg_we} !== {(c == 10), (c == 10)}) begin
        errors++; $display("FAIL lw_strobes c%0d: got %b required %b", c, {pc_we, reg_we}, {(c == 10), (c == 10)});
      end
      if (c == 6) begin
        checks++;
        if ({dmem_req, dmem_we, alu_src, alu_op} !== 5'b10_1_00) begin
          errors++; $display("FAIL lw_mem_hold: got %b required 10100", {dmem_req, dmem_we, alu_src, alu_op});
        end
      end
      if (c == 10) begin
        checks++;
        if ({wb_sel, reg_dst, pc_sel} !== 6'b01_00_00) begin
          errors++; $display("FAIL lw_wb_ctrl: got %b required 010000", {wb_sel, reg_dst, pc_sel});
        end
      end
    end
    checks++;
    if (req_cycles != 6) begin errors++; $display("FAIL lw_dmem_req_cycles: got %0d required 6", req_cycles); end
  endtask

  task automatic test_sw();
    for (int c = 1; c <= 4; c++) begin
      tick((c == 1) ? I_SW : 32'h0000_0000, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({pc_we, reg_we} !== {(c == 4), 1'b0}) begin
        errors++; $display("FAIL sw_strobes c%0d: got %b required %b", c, {pc_we, reg_we}, {(c == 4), 1'b0});
      end
      if (c == 4) begin
        checks++;
        if ({dmem_req, dmem_we, pc_sel} !== 4'b11_00) begin
          errors++; $display("FAIL sw_mem: got %b required 1100", {dmem_req, dmem_we, pc_sel});
        end
      end
    end
  endtask

  task automatic test_jumps();
    for (int v = 0; v < 3; v++) begin
      for (int c = 1; c <= 2; c++) begin
        tick((c == 1) ? JMP_INSTR[v] : 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pc_we !== (c == 2)) begin errors++; $display("FAIL jmp%0d_pc_we c%0d: got %b required %b", v, c, pc_we, c == 2); end
        if (c == 2) begin
          checks++;
          if ({pc_sel, reg_we} !== {JMP_SEL[v], JMP_LINK[v]}) begin
            errors++; $display("FAIL jmp%0d_ctrl: got %b required %b", v, {pc_sel, reg_we}, {JMP_SEL[v], JMP_LINK[v]});
          end
          if (JMP_LINK[v]) begin
            checks++;
            if ({reg_dst, wb_sel} !== 4'b10_10) begin
              errors++; $display("FAIL jal_link: got %b required 1010", {reg_dst, wb_sel});
            end
          end
        end
      end
    end
  endtask

  task automatic test_illegal();
    for (int v = 0; v < 2; v++) begin
      for (int c = 1; c <= 2; c++) begin
        tick((c == 1) ? ILL_INSTR[v] : 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({illegal, pc_we, reg_we} !== {(c == 2), (c == 2), 1'b0}) begin
          errors++; $display("FAIL ill%0d_strobes c%0d: got %b required %b", v, c, {illegal, pc_we, reg_we}, {(c == 2), (c == 2), 1'b0});
        end
        if (c == 2) begin
          checks++;
          if (pc_sel !== 2'd0) begin errors++; $display("FAIL ill%0d_pc_sel: got %0d required 0", v, pc_sel); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 1; c <= 6; c++) begin
      tick((c == 1) ? I_J : ((c == 3) ? I_ADDI : 32'h0000_0000), 1'b1, 1'b1, 1'b0);
      checks++;
      if (pc_we !== ((c == 2) || (c == 6))) begin
        errors++; $display("FAIL b2b_pc_we c%0d: got %b required %b", c, pc_we, (c == 2) || (c == 6));
      end
    end
  endtask

  task automatic test_abort();
    for (int c = 1; c <= 3; c++) tick((c == 1) ? I_ADD : 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1; #1;
    checks++;
    if ({pc_we, reg_we} !== 2'b00) begin errors++; $display("FAIL abort_strobes: got %b required 00", {pc_we, reg_we}); end
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b0; #1;
    checks++;
    if ({imem_req, pc_we, reg_we} !== 3'b100) begin
      errors++; $display("FAIL abort_refetch: got %b required 100", {imem_req, pc_we, reg_we});
    end
  endtask

  task automatic test_watchdog();
    wd_instr = I_J; wd_imem_ready = 1'b0;
    @(negedge clk);
    wd_reset = 1'b0; #1;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) begin @(negedge clk); wd_imem_ready = (k >= 5); #1; end
      checks++;
      if ({wd_imem_req, wd_bus_err, wd_pc_we, wd_ir_we} !== {(k <= 4), (k >= 5), 2'b00}) begin
        errors++; $display("FAIL wd_expire k%0d: got %b required %b", k,
                           {wd_imem_req, wd_bus_err, wd_pc_we, wd_ir_we}, {(k <= 4), (k >= 5), 2'b00});
      end
    end
    wd_reset = 1'b1; #1;
    checks++;
    if (wd_bus_err !== 1'b0) begin errors++; $display("FAIL wd_reset_clears: got %b required 0", wd_bus_err); end
    @(negedge clk);
    wd_reset = 1'b0; wd_imem_ready = 1'b0; #1;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin @(negedge clk); wd_imem_ready = (k == 4); #1; end
      checks++;
      if ({wd_bus_err, wd_ir_we, wd_pc_we} !== {1'b0, (k == 4), (k == 5)}) begin
        errors++; $display("FAIL wd_race k%0d: got %b required %b", k, {wd_bus_err, wd_ir_we, wd_pc_we}, {1'b0, (k == 4), (k == 5)});
      end
      if (k == 5) begin
        checks++;
        if (wd_pc_sel !== 2'd1) begin errors++; $display("FAIL wd_race_jump: got %0d required 1", wd_pc_sel); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu();
    test_branch();
    test_lw_wait();
    test_sw();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_abort();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
